// File: rtl/aes_rx_ctrl.sv
// Byte-stream front end for an AES core: collects 16-byte key and plaintext frames and sequences the core.
// Optional inter-byte frame timeout is enabled by defining AES_RX_TIMEOUT_EN.
module aes_rx_ctrl #(
    parameter logic [7:0]  KEY_CMD        = 8'h4B,
    parameter logic [7:0]  BLK_CMD        = 8'h44,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         aes_busy,
    input  logic         aes_done,
    output logic [127:0] key_out,
    output logic         key_load,
    output logic [127:0] blk_out,
    output logic         blk_start,
    output logic         busy,
    output logic         err,
    output logic         overrun
);

    typedef enum logic [2:0] {IDLE, RX_KEY, RX_BLK, ISSUE, WAIT} state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [3:0]     r_cnt;
    logic           r_key_ok;
    logic [127:0]   r_key_sh;
    logic [127:0]   r_key_out;
    logic [127:0]   r_blk;
    logic           r_key_load;
    logic           r_err;
    logic           r_overrun;

    logic           w_err_set;
    logic           w_ovr_set;
    logic           w_key_done;
    logic           w_blk_start;
    logic           w_shift_key;
    logic           w_shift_blk;
    logic           w_cnt_clr;
    logic           w_tmo_hit;

`ifdef AES_RX_TIMEOUT_EN
    logic [31:0]    r_tmo;

    // Counts idle cycles inside a frame; any byte or any other state restarts it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tmo <= 32'd0;
        end else if ((r_state == RX_KEY || r_state == RX_BLK) && !rx_valid) begin
            r_tmo <= r_tmo + 32'd1;
        end else begin
            r_tmo <= 32'd0;
        end
    end

    assign w_tmo_hit = (r_tmo + 32'd1 == TIMEOUT_CYCLES);
`else
    logic           w_unused_tmo;

    assign w_unused_tmo = |TIMEOUT_CYCLES;
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        w_next_state = r_state;
        w_err_set    = 1'b0;
        w_ovr_set    = 1'b0;
        w_key_done   = 1'b0;
        w_blk_start  = 1'b0;
        w_shift_key  = 1'b0;
        w_shift_blk  = 1'b0;
        w_cnt_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == KEY_CMD) begin
                        w_next_state = RX_KEY;
                        w_cnt_clr    = 1'b1;
                    end else if (rx_data == BLK_CMD && r_key_ok) begin
                        w_next_state = RX_BLK;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_err_set    = 1'b1;
                    end
                end
            end
            RX_KEY: begin
                if (rx_valid) begin
                    w_shift_key = 1'b1;
                    if (r_cnt == 4'd15) begin
                        w_key_done   = 1'b1;
                        w_next_state = IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            RX_BLK: begin
                if (rx_valid) begin
                    w_shift_blk = 1'b1;
                    if (r_cnt == 4'd15) begin
                        w_next_state = ISSUE;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                w_ovr_set = rx_valid;
                if (!aes_busy) begin
                    w_blk_start  = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                w_ovr_set = rx_valid;
                if (aes_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The key is staged in a shadow register so a partial or abandoned frame never disturbs key_out.
    always_ff @(posedge clk) begin
        // NOTE: every register here is cleared by reset, because software may read key_out/blk_out straight after it.
        if (!rstn) begin
            r_cnt      <= 4'd0;
            r_key_ok   <= 1'b0;
            r_key_sh   <= 128'd0;
            r_key_out  <= 128'd0;
            r_blk      <= 128'd0;
            r_key_load <= 1'b0;
            r_err      <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every right-hand side reads the pre-edge value.
            r_key_load <= w_key_done;
            r_err      <= w_err_set;
            r_overrun  <= w_ovr_set;
            if (w_cnt_clr) begin
                r_cnt <= 4'd0;
            end else if (w_shift_key || w_shift_blk) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_shift_key) begin
                r_key_sh <= {r_key_sh[119:0], rx_data};
            end
            if (w_key_done) begin
                r_key_out <= {r_key_sh[119:0], rx_data};
                r_key_ok  <= 1'b1;
            end
            if (w_shift_blk) begin
                r_blk <= {r_blk[119:0], rx_data};
            end
        end
    end

    assign key_out   = r_key_out;
    assign key_load  = r_key_load;
    assign blk_out   = r_blk;
    assign blk_start = w_blk_start;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_aes_rx_ctrl.sv
// Scoreboard bench for aes_rx_ctrl: stimulus pushes expected strobe events, a negedge monitor pops and compares.
module tb_aes_rx_ctrl;

    localparam logic [1:0] EV_KEY = 2'd0;
    localparam logic [1:0] EV_BLK = 2'd1;
    localparam logic [1:0] EV_ERR = 2'd2;
    localparam logic [1:0] EV_OVR = 2'd3;

    typedef struct {
        logic [1:0]   kind;
        logic [127:0] data;
    } ev_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         aes_busy;
    logic         aes_done;
    logic [127:0] key_out;
    logic         key_load;
    logic [127:0] blk_out;
    logic         blk_start;
    logic         busy;
    logic         err;
    logic         overrun;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    aes_rx_ctrl #(
        .KEY_CMD        (8'h4B),
        .BLK_CMD        (8'h44),
        .TIMEOUT_CYCLES (32'd100)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .aes_busy  (aes_busy),
        .aes_done  (aes_done),
        .key_out   (key_out),
        .key_load  (key_load),
        .blk_out   (blk_out),
        .blk_start (blk_start),
        .busy      (busy),
        .err       (err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [1:0] k, input logic [127:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic mon_pop(input logic [1:0] k, input logic [127:0] d);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual_kind=%0d required=none", k);
        end else begin
            e = q.pop_front();
            check("event_kind", {126'd0, k}, {126'd0, e.kind});
            check("event_data", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (key_load || blk_start) check("key_load_blk_start_exclusive", {127'd0, key_load && blk_start}, 128'd0);
            if (key_load)  mon_pop(EV_KEY, key_out);
            if (blk_start) mon_pop(EV_BLK, blk_out);
            if (err)       mon_pop(EV_ERR, 128'd0);
            if (overrun)   mon_pop(EV_OVR, 128'd0);
        end
    end

    // Called at posedge+1; leaves rx_valid low at the following posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 128'(q.size()), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        aes_busy = 1'b0;
        aes_done = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_key_out",   key_out, 128'd0);
        check("rst_blk_out",   blk_out, 128'd0);
        check("rst_strobes",   {124'd0, key_load, blk_start, err, overrun}, 128'd0);
        check("rst_busy",      {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        // Block command with no key loaded
        push_ev(EV_ERR, 128'd0);
        send_byte(8'h44);
        @(negedge clk);
        check("blk_no_key_busy", {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;
        wait_drain("drain_blk_no_key", 10);

        // Unknown command byte
        push_ev(EV_ERR, 128'd0);
        send_byte(8'h12);
        wait_drain("drain_bad_cmd", 10);

        // Key frame 00..0F
        push_ev(EV_KEY, 128'h000102030405060708090A0B0C0D0E0F);
        send_byte(8'h4B);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            if (i == 7) begin
                @(negedge clk);
                check("key_frame_busy", {127'd0, busy}, 128'd1);
                @(posedge clk);
                #1;
            end
        end
        wait_drain("drain_key1", 10);
        @(negedge clk);
        check("key_idle_busy", {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;

        // Block frame of 0xAA while the core is busy for 5 cycles
        aes_busy = 1'b1;
        push_ev(EV_BLK, {16{8'hAA}});
        send_byte(8'h44);
        for (int i = 0; i < 16; i++) send_byte(8'hAA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("issue_hold_blk_start", {127'd0, blk_start}, 128'd0);
            @(posedge clk);
            #1;
        end
        aes_busy = 1'b0;
        @(negedge clk);
        check("issue_blk_start", {127'd0, blk_start}, 128'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wait_blk_out_stable", blk_out, {16{8'hAA}});
        check("wait_busy", {127'd0, busy}, 128'd1);
        @(posedge clk);
        #1;

        // Overrun in WAIT, then a byte coinciding with aes_done
        push_ev(EV_OVR, 128'd0);
        send_byte(8'h55);
        push_ev(EV_OVR, 128'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h4B;
        aes_done = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        aes_done = 1'b0;
        @(negedge clk);
        check("done_overrun_idle", {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;
        idle(2);
        @(negedge clk);
        check("dropped_byte_ignored", {127'd0, busy}, 128'd0);
        check("blk_out_after_wait", blk_out, {16{8'hAA}});
        @(posedge clk);
        #1;
        wait_drain("drain_overrun", 10);

        // Reset mid-frame after 7 key bytes
        send_byte(8'h4B);
        for (int i = 0; i < 7; i++) send_byte(8'hF0 + 8'(i));
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("midframe_rst_key_out", key_out, 128'd0);
        check("midframe_rst_busy", {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;
        push_ev(EV_ERR, 128'd0);
        send_byte(8'h44);
        wait_drain("drain_key_ok_cleared", 10);
        push_ev(EV_KEY, 128'h101112131415161718191A1B1C1D1E1F);
        send_byte(8'h4B);
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        wait_drain("drain_key2", 10);

`ifdef AES_RX_TIMEOUT_EN
        // Stall mid-frame until the timeout fires
        push_ev(EV_ERR, 128'd0);
        send_byte(8'h4B);
        for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
        wait_drain("drain_timeout", 200);
        idle(2);
        @(negedge clk);
        check("timeout_idle", {127'd0, busy}, 128'd0);
        check("timeout_key_kept", key_out, 128'h101112131415161718191A1B1C1D1E1F);
        @(posedge clk);
        #1;
`else
        // Long stall mid-frame, then complete the frame
        push_ev(EV_KEY, 128'h202122232425262728292A2B2C2D2E2F);
        send_byte(8'h4B);
        for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
        idle(150);
        @(negedge clk);
        check("stall_still_busy", {127'd0, busy}, 128'd1);
        check("stall_key_kept", key_out, 128'h101112131415161718191A1B1C1D1E1F);
        @(posedge clk);
        #1;
        for (int i = 5; i < 16; i++) send_byte(8'h20 + 8'(i));
        wait_drain("drain_key3", 10);
`endif

        idle(5);
        check("final_queue_empty", 128'(q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_rx_ctrl.md
AES_RX_CTRL -- requirements
Module: aes_rx_ctrl

Interface
REQ-001 SHALL have parameter KEY_CMD, default 8'h4B, meaning the command byte that opens a 16-byte key frame.
REQ-002 SHALL have parameter BLK_CMD, default 8'h44, meaning the command byte that opens a 16-byte plaintext frame.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32'd1000000, meaning the maximum allowed clock gap between bytes within a frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port rx_valid, input, 1 bit: single-cycle strobe marking a received byte.
REQ-007 SHALL have port rx_data, input, 8 bits: received byte, sampled when rx_valid=1.
REQ-008 SHALL have port aes_busy, input, 1 bit: the AES core is processing.
REQ-009 SHALL have port aes_done, input, 1 bit: single-cycle strobe marking AES completion.
REQ-010 SHALL have port key_out, output, 128 bits: assembled key.
REQ-011 SHALL have port key_load, output, 1 bit: one-cycle strobe marking key_out valid.
REQ-012 SHALL have port blk_out, output, 128 bits: assembled plaintext block.
REQ-013 SHALL have port blk_start, output, 1 bit: one-cycle strobe that starts the AES core.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port err, output, 1 bit: one-cycle strobe flagging a protocol error.
REQ-016 SHALL have port overrun, output, 1 bit: one-cycle strobe flagging a dropped byte.

Function
REQ-017 SHALL implement states IDLE, RX_KEY, RX_BLK, ISSUE and WAIT.
REQ-018 In IDLE, on rx_valid with rx_data==KEY_CMD, SHALL go to RX_KEY and clear the 4-bit byte counter.
REQ-019 In IDLE, on rx_valid with rx_data==BLK_CMD and key_ok=1, SHALL go to RX_BLK and clear the counter.
REQ-020 In IDLE, on BLK_CMD with key_ok=0, or on any other byte value, SHALL pulse err for one cycle and stay in IDLE.
REQ-021 In RX_KEY and RX_BLK, each rx_valid SHALL shift the byte into the target register MSB-first, so the first frame byte lands in [127:120] and the 16th in [7:0].
REQ-022 The counter SHALL increment on each frame byte; on the byte taken at counter==15 the counter SHALL wrap to 0.
REQ-023 After the 16th key byte, SHALL pulse key_load the next cycle, set key_ok=1 and return to IDLE.
REQ-024 key_out SHALL change only while in RX_KEY and SHALL hold between frames.
REQ-025 After the 16th block byte, SHALL enter ISSUE.
REQ-026 In ISSUE, SHALL pulse blk_start for one cycle, in the first cycle with aes_busy=0, then enter WAIT.
REQ-027 blk_out SHALL be stable from ISSUE until WAIT exits.
REQ-028 In WAIT, on aes_done, SHALL return to IDLE.
REQ-029 Any rx_valid in ISSUE or WAIT SHALL be dropped with a one-cycle overrun pulse; this applies even when aes_done arrives in the same cycle.
REQ-030 key_load and blk_start SHALL never be asserted in the same cycle.

Reset
REQ-031 On a rising clk edge with rstn=0, SHALL enter IDLE and clear the counter, key_ok, key_out, blk_out, key_load, blk_start, err and overrun; busy SHALL read 0.
REQ-032 A reset mid-frame SHALL discard the partial frame; the next frame SHALL require a fresh command byte.

Configuration
REQ-033 With macro AES_RX_TIMEOUT_EN defined, a cycle counter SHALL clear on every frame byte in RX_KEY or RX_BLK.
REQ-034 With AES_RX_TIMEOUT_EN defined, the count reaching TIMEOUT_CYCLES SHALL pulse err, discard the frame and return to IDLE, leaving key_out and key_ok unchanged.
REQ-035 Without AES_RX_TIMEOUT_EN, SHALL have no timeout counter and SHALL wait indefinitely for frame bytes.

Verification
REQ-036 Bench SHALL send 0x4B then bytes 0x00..0x0F -> one key_load pulse with key_out=128'h000102030405060708090A0B0C0D0E0F.
REQ-037 Bench SHALL send 0x44 after reset with no key -> err pulse, busy stays 0, no blk_start.
REQ-038 Bench SHALL load a key, send 0x44 plus 16 bytes of 0xAA with aes_busy=1 for 5 cycles -> blk_start exactly once, in the first cycle aes_busy=0, with blk_out=all-0xAA.
REQ-039 Bench SHALL send rx_valid in WAIT in the same cycle as aes_done -> overrun pulse, return to IDLE, byte ignored.
REQ-040 Bench SHALL assert rstn=0 after 7 key bytes, then send a full key frame -> key_out equals the new frame only.
REQ-041 Bench SHALL, with AES_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100, stall 100 cycles mid-frame -> err pulse, IDLE, previous key_out retained.
